// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops (A, B, opcode) from the RX FIFO, runs the ALU for one cycle, pushes the result byte.
// Optional inter-byte timeout enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
    parameter int DBIT           = 8,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] rx_data,
    output logic            rx_rd,
    input  logic            tx_full,
    output logic            tx_wr,
    output logic [DBIT-1:0] tx_data,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [DBIT-1:0] alu_result,
    output logic            frame_done,
    output logic            timeout_err
);

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_EXEC,
        ST_SEND
    } state_t;

    state_t          state_q, state_d;
    logic [DBIT-1:0] a_q, a_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [DBIT-1:0] result_q, result_d;
    logic            tmo_hit;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;

    // Counts only while starved mid-frame; any pop or state change clears it.
    always_comb begin
        waiting = ((state_q == ST_GET_B) || (state_q == ST_GET_OP)) && rx_empty;
        tmo_hit = waiting && (cnt_q == TMO_LAST);
        cnt_d   = (waiting && !tmo_hit) ? cnt_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        rx_rd    = 1'b0;
        tx_wr    = 1'b0;
        case (state_q)
            ST_GET_A: begin
                if (!rx_empty) begin
                    rx_rd   = 1'b1;
                    a_d     = rx_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (!rx_empty) begin
                    rx_rd   = 1'b1;
                    b_d     = rx_data;
                    state_d = ST_GET_OP;
                end else if (tmo_hit) begin
                    state_d = ST_GET_A;
                end
            end
            ST_GET_OP: begin
                if (!rx_empty) begin
                    rx_rd   = 1'b1;
                    op_d    = rx_data[OP_W-1:0];
                    state_d = ST_EXEC;
                end else if (tmo_hit) begin
                    state_d = ST_GET_A;
                end
            end
            // Operands have been stable for this whole cycle, so the ALU output is settled here.
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_full) begin
                    tx_wr   = 1'b1;
                    state_d = ST_GET_A;
                end
            end
            default: begin
                state_d = ST_GET_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_GET_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    // Opcode bits above OP_W are intentionally ignored.
    if (OP_W < DBIT) begin : g_rx_hi
        logic unused_rx_hi;
        assign unused_rx_hi = ^rx_data[DBIT-1:OP_W];
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign tx_data     = result_q;
    assign frame_done  = tx_wr;
    assign timeout_err = tmo_hit;

endmodule
